pipe_reg_file: RTL and testbench

PIPE_REG_FILE -- requirements
Module: pipe_reg_file

---
 rtl/pipe_reg_file.sv | 90 +++++++++
 tb/tb_pipe_reg_file.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_file.sv
// Multi-ported register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding, busy population count and reserve-conflict flag.
module pipe_reg_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 2,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          write_data,
   input  logic [ADDR_WIDTH-1:0]          write_reg,
   input  logic                           reg_write,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg,
   output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
   output logic [NUM_READ-1:0]            read_busy,
   input  logic                           reserve_en,
   input  logic [ADDR_WIDTH-1:0]          reserve_reg,
   output logic [ADDR_WIDTH:0]            busy_count,
   output logic                           reserve_conflict
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [Depth];
   logic [Depth-1:0]      busy_q, busy_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  conflict_q, conflict_d;
   logic                  wr_en, rsv_en;

   // Register 0 is excluded from both writes and reservations.
   assign wr_en  = reg_write && (write_reg != '0);
   assign rsv_en = reserve_en && (reserve_reg != '0);

   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[write_reg] = 1'b0;
      end
      // A new reservation overrides a same-edge completion.
      if (rsv_en) begin
         busy_d[reserve_reg] = 1'b1;
      end
      busy_d[0] = 1'b0;

      conflict_d = rsv_en && busy_q[reserve_reg] && !(wr_en && (write_reg == reserve_reg));

      count_d = '0;
      for (int k = 0; k < Depth; k++) begin
         count_d = count_d + {{ADDR_WIDTH{1'b0}}, busy_d[k]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < Depth; k++) begin
            regs_q[k] <= '0;
         end
      end else if (wr_en) begin
         regs_q[write_reg] <= write_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q     <= '0;
         count_q    <= '0;
         conflict_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         count_q    <= count_d;
         conflict_q <= conflict_d;
      end
   end

   assign busy_count       = count_q;
   assign reserve_conflict = conflict_q;

   for (genvar i = 0; i < NUM_READ; i++) begin : g_read
      logic [ADDR_WIDTH-1:0] addr;
      logic                  fwd;

      assign addr = read_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign fwd  = (BYPASS != 0) && wr_en && (write_reg == addr);

      assign read_data[i*DATA_WIDTH +: DATA_WIDTH] = fwd ? write_data : regs_q[addr];
      assign read_busy[i]                          = fwd ? 1'b0 : busy_q[addr];
   end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Bench for pipe_reg_file: bypassing and non-bypassing instances share stimulus and are
// checked every cycle against an array/scoreboard model, plus directed literal checks.
module tb_pipe_reg_file;

   logic        clk;
   logic        rst;
   logic [31:0] write_data;
   logic [4:0]  write_reg;
   logic        reg_write;
   logic [9:0]  read_reg;
   logic        reserve_en;
   logic [4:0]  reserve_reg;

   logic [63:0] rd1, rd0;
   logic [1:0]  rb1, rb0;
   logic [5:0]  cnt1, cnt0;
   logic        conf1, conf0;

   int nchk  = 0;
   int nfail = 0;
   logic chk_en;

   pipe_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(1)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .write_data       (write_data),
      .write_reg        (write_reg),
      .reg_write        (reg_write),
      .read_reg         (read_reg),
      .read_data        (rd1),
      .read_busy        (rb1),
      .reserve_en       (reserve_en),
      .reserve_reg      (reserve_reg),
      .busy_count       (cnt1),
      .reserve_conflict (conf1)
   );

   pipe_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(0)) u_dut_nb (
      .clk              (clk),
      .rst              (rst),
      .write_data       (write_data),
      .write_reg        (write_reg),
      .reg_write        (reg_write),
      .read_reg         (read_reg),
      .read_data        (rd0),
      .read_busy        (rb0),
      .reserve_en       (reserve_en),
      .reserve_reg      (reserve_reg),
      .busy_count       (cnt0),
      .reserve_conflict (conf0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register contents, busy flags, pending conflict pulse.
   logic [31:0] m_mem  [32];
   logic        m_busy [32];
   logic        m_conf;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 32; k++) begin
            m_mem[k]  <= '0;
            m_busy[k] <= 1'b0;
         end
         m_conf <= 1'b0;
      end else begin
         if (reg_write && write_reg != 0) begin
            m_mem[write_reg]  <= write_data;
            m_busy[write_reg] <= 1'b0;
         end
         if (reserve_en && reserve_reg != 0) begin
            m_busy[reserve_reg] <= 1'b1;
         end
         m_conf <= reserve_en && reserve_reg != 0 && m_busy[reserve_reg]
                   && !(reg_write && write_reg == reserve_reg);
      end
   end

   logic [4:0]  c_addr;
   logic        c_fwd;
   logic [5:0]  c_pop;

   always @(negedge clk) begin
      if (rst && chk_en) begin
         for (int i = 0; i < 2; i++) begin
            c_addr = read_reg[i*5 +: 5];
            c_fwd  = reg_write && write_reg != 0 && write_reg == c_addr;
            check("read_data_bypass", {32'd0, rd1[i*32 +: 32]},
                  {32'd0, c_fwd ? write_data : m_mem[c_addr]});
            check("read_busy_bypass", {63'd0, rb1[i]}, {63'd0, c_fwd ? 1'b0 : m_busy[c_addr]});
            check("read_data_nobypass", {32'd0, rd0[i*32 +: 32]}, {32'd0, m_mem[c_addr]});
            check("read_busy_nobypass", {63'd0, rb0[i]}, {63'd0, m_busy[c_addr]});
         end
         c_pop = '0;
         for (int k = 0; k < 32; k++) begin
            if (m_busy[k]) c_pop = c_pop + 6'd1;
         end
         check("busy_count", {58'd0, cnt1}, {58'd0, c_pop});
         check("busy_count_nb", {58'd0, cnt0}, {58'd0, c_pop});
         check("reserve_conflict", {63'd0, conf1}, {63'd0, m_conf});
         check("reserve_conflict_nb", {63'd0, conf0}, {63'd0, m_conf});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reg_write  = 1'b0;
      reserve_en = 1'b0;
   endtask

   initial begin
      chk_en      = 1'b1;
      rst         = 1'b0;
      write_data  = '0;
      write_reg   = '0;
      reg_write   = 1'b0;
      read_reg    = '0;
      reserve_en  = 1'b0;
      reserve_reg = '0;
      #3;
      check("reset_count", {58'd0, cnt1}, 64'd0);
      check("reset_conflict", {63'd0, conf1}, 64'd0);
      check("reset_read", rd1, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // r0 is immune to writes and reservations
      reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
      reserve_en = 1'b1; reserve_reg = 5'd0; read_reg = {5'd0, 5'd0};
      step(); idle(); #1;
      check("r0_read", rd1, 64'd0);
      check("r0_count", {58'd0, cnt1}, 64'd0);
      check("r0_conflict", {63'd0, conf1}, 64'd0);

      // write then read next cycle
      reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
      step(); idle(); read_reg = {5'd0, 5'd5}; #1;
      check("r5_port0", {32'd0, rd1[31:0]}, 64'hDEAD_BEEF);
      check("r0_port1", {32'd0, rd1[63:32]}, 64'd0);

      // same-cycle forwarding vs stored value
      reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h1234_5678; read_reg = {5'd0, 5'd7}; #1;
      check("bypass_same_cycle", {32'd0, rd1[31:0]}, 64'h1234_5678);
      check("nobypass_same_cycle", {32'd0, rd0[31:0]}, 64'd0);
      step(); idle(); #1;
      check("nobypass_next_cycle", {32'd0, rd0[31:0]}, 64'h1234_5678);

      // reserve r3, r4; complete r3
      reserve_en = 1'b1; reserve_reg = 5'd3; step();
      reserve_reg = 5'd4; step(); idle(); read_reg = {5'd0, 5'd3}; #1;
      check("count_two", {58'd0, cnt1}, 64'd2);
      check("r3_busy", {63'd0, rb1[0]}, 64'd1);
      reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h0000_0033;
      step(); idle(); #1;
      check("count_one", {58'd0, cnt1}, 64'd1);
      check("r3_free", {63'd0, rb1[0]}, 64'd0);

      // same-edge reserve and write to r9, then re-reserve
      reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hA5A5_A5A5;
      reserve_en = 1'b1; reserve_reg = 5'd9;
      step(); idle(); read_reg = {5'd9, 5'd9}; #1;
      check("r9_data", rd1, 64'hA5A5_A5A5_A5A5_A5A5);
      check("r9_busy", {62'd0, rb1}, 64'd3);
      check("count_r9", {58'd0, cnt1}, 64'd2);
      check("r9_no_conflict", {63'd0, conf1}, 64'd0);
      reserve_en = 1'b1; reserve_reg = 5'd9;
      step(); idle(); #1;
      check("r9_conflict", {63'd0, conf1}, 64'd1);
      check("r9_conflict_count", {58'd0, cnt1}, 64'd2);
      step(); #1;
      check("r9_conflict_drop", {63'd0, conf1}, 64'd0);

      // randomized traffic with collisions biased in
      for (int n = 0; n < 3000; n++) begin
         reg_write  = 1'($urandom_range(0, 1));
         write_reg  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         write_data = $urandom;
         reserve_en = 1'($urandom_range(0, 1));
         reserve_reg = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 31));
         read_reg[4:0] = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 31));
         read_reg[9:5] = ($urandom_range(0, 3) == 0) ? read_reg[4:0] : 5'($urandom_range(0, 31));
         step();
      end

      // fill, reserve, then asynchronous reset between edges
      idle();
      for (int k = 1; k < 32; k++) begin
         reg_write = 1'b1; write_reg = 5'(k); write_data = $urandom | 32'h1;
         step();
      end
      idle();
      reserve_en = 1'b1;
      reserve_reg = 5'd3; step();
      reserve_reg = 5'd8; step();
      reserve_reg = 5'd20; step();
      idle(); read_reg = {5'd31, 5'd1};
      #2 rst = 1'b0;
      #1;
      check("async_rst_read", rd1, 64'd0);
      check("async_rst_read_nb", rd0, 64'd0);
      check("async_rst_busy", {62'd0, rb1}, 64'd0);
      check("async_rst_count", {58'd0, cnt1}, 64'd0);
      check("async_rst_conflict", {63'd0, conf1}, 64'd0);
      reg_write = 1'b1; write_reg = 5'd12; write_data = 32'hCAFE_F00D;
      reserve_en = 1'b1; reserve_reg = 5'd12;
      step(); idle(); read_reg = {5'd12, 5'd12};
      #1 rst = 1'b1;
      #1;
      check("post_rst_read", rd1, 64'd0);
      check("post_rst_count", {58'd0, cnt1}, 64'd0);
      reg_write = 1'b1; write_reg = 5'd12; write_data = 32'h0BAD_CAFE;
      step(); idle(); #1;
      check("first_edge_write", {32'd0, rd0[31:0]}, 64'h0BAD_CAFE);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
